// File: rtl/fifo_write_arbiter_pkg.sv
// Shared defaults, FSM encodings and helpers for the FIFO write-port arbiter.
// Imported by the top level and by the round-robin picker.
package fifo_write_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int N_REQ_DEF      = 4;
  localparam int MAX_BURST_DEF  = 8;

  // Two-state arbiter encodings, kept as plain constants for legacy users.
  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  // Wraps a requester index into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the search
// starts just above the last winner, find the first set bit, then un-rotate.
module rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                any,
  output logic [ID_WIDTH-1:0] idx
);

  logic [N_REQ-1:0] rot;
  int               start;
  int               off;
  logic             found;

  always_comb begin
    start = rr_wrap(int'(last) + 1, N_REQ);
    rot   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = req[ID_WIDTH'(rr_wrap(start + k, N_REQ))];
    end
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot[k] && !found) begin
        found = 1'b1;
        off   = k;
      end
    end
    any = |req;
    idx = ID_WIDTH'(rr_wrap(start + off, N_REQ));
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the FIFO write port among N_REQ requesters: round-robin choice in
// IDLE, grant locked to one requester until its packet ends or MAX_BURST beats.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_REQ      = N_REQ_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int ID_WIDTH   = $clog2(N_REQ),
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        wr_valid,
  output logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_full,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        busy,
  output logic [0:0]                  dbg_state,
  output logic [CNT_WIDTH-1:0]        dbg_beat_cnt
);

  // Handshakes: a requester beat moves when req_valid[i] & req_ready[i]; a
  // FIFO write happens when wr_valid & !wr_full. valid never waits on ready,
  // and ready is only ever high for the granted requester.

  logic [0:0]           state;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 pick_any;
  logic [ID_WIDTH-1:0]  pick_id;
  logic                 gnt_valid;
  logic                 gnt_last;
  logic                 accept;
  logic                 release_beat;

  rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req  (req_valid),
    .last (grant_id),
    .any  (pick_any),
    .idx  (pick_id)
  );

  always_comb begin
    gnt_valid = req_valid[grant_id];
    gnt_last  = req_last[grant_id];
    wr_valid  = 1'b0;
    wr_data   = '0;
    req_ready = '0;
    if (state == ARB_GRANT) begin
      wr_valid            = gnt_valid;
      req_ready[grant_id] = gnt_valid & ~wr_full;
      for (int i = 0; i < N_REQ; i++) begin
        if (ID_WIDTH'(i) == grant_id) begin
          wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign accept       = wr_valid & ~wr_full;
  // Release on end of packet or on the beat that fills the burst allowance.
  assign release_beat = gnt_last | (beat_cnt == CNT_WIDTH'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      grant_id <= ID_WIDTH'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (release_beat) begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy         = (state == ARB_GRANT);
  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: packet-queue requester models, a
// beat scoreboard and per-cycle grant/handshake checks.
module tb_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int BW = IW + DW;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_last;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               wr_valid;
  logic [DW-1:0]      wr_data;
  logic               wr_full;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic [0:0]         dbg_state;
  logic [CW-1:0]      dbg_beat_cnt;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_beat_cnt (dbg_beat_cnt)
  );

  // Requester models: remaining beats of the current packet, beat sequence, gap.
  int            rq_len[NR];
  int            rq_seq[NR];
  logic [NR-1:0] rq_hold;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (rq_len[i] != 0) && !rq_hold[i];
      req_last[i]           = (rq_len[i] == 1);
      req_data[i*DW +: DW]  = {2'(i), 6'(rq_seq[i])};
    end
  end

  logic [BW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  logic          s_busy;
  logic [IW-1:0] s_gid;
  logic          s_wrv;
  logic [NR-1:0] s_rdy;
  logic [CW-1:0] s_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int id, input int seq);
    return {2'(id), 2'(id), 6'(seq)};
  endfunction

  task automatic zero_seq();
    for (int i = 0; i < NR; i++) rq_seq[i] = 0;
  endtask

  // One clock: sample at negedge, score any accepted beat, advance models.
  task automatic step();
    logic [BW-1:0] e;
    logic [NR-1:0] rdy_s;
    @(negedge clk);
    s_busy = busy;
    s_gid  = grant_id;
    s_wrv  = wr_valid;
    s_rdy  = req_ready;
    s_cnt  = dbg_beat_cnt;
    if (wr_valid && !wr_full) begin
      if (exp_q.size() == 0) begin
        check("beat_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({grant_id, wr_data}), 32'(e));
        check("beat_ready", 32'(req_ready), 32'(4'b0001 << e[BW-1 -: IW]));
      end
    end
    rdy_s = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy_s[i]) begin
        rq_len[i]--;
        rq_seq[i]++;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || s_busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  logic [10:0] busy_t;
  int          gid_t[11];

  initial begin
    reset_n = 1'b0;
    wr_full = 1'b0;
    rq_hold = '0;
    for (int i = 0; i < NR; i++) begin
      rq_len[i] = 0;
      rq_seq[i] = 0;
    end
    s_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_beat_cnt", 32'(dbg_beat_cnt), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    reset_n = 1'b1;

    // Reset priority: single-beat packets, grants 0,1,2,3,0 with bubbles.
    busy_t = 11'b01010101010;
    gid_t  = '{0, 0, 0, 1, 0, 2, 0, 3, 0, 0, 0};
    for (int i = 0; i < NR; i++) rq_len[i] = 1;
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(1, 0));
    exp_q.push_back(mk(2, 0));
    exp_q.push_back(mk(3, 0));
    exp_q.push_back(mk(0, 1));
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 1) rq_len[0] = 1;
      check($sformatf("prio_busy_c%0d", c), 32'(s_busy), 32'(busy_t[c]));
      if (busy_t[c]) check($sformatf("prio_gid_c%0d", c), 32'(s_gid), 32'(gid_t[c]));
    end
    wait_drain(20);

    // Packet lock: requester 2 keeps the port for 3 beats while 1 waits.
    zero_seq();
    rq_len[2] = 3;
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(2, b));
    for (int b = 0; b < 2; b++) exp_q.push_back(mk(1, b));
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) rq_len[1] = 2;
      if (c >= 1 && c <= 3) begin
        check($sformatf("lock_gid_c%0d", c), 32'(s_gid), 32'd2);
        check($sformatf("lock_wrv_c%0d", c), 32'(s_wrv), 32'd1);
      end
      if (c == 4) check("lock_bubble", 32'(s_busy), 32'd0);
      if (c == 5) check("lock_next_gid", 32'(s_gid), 32'd1);
    end
    wait_drain(20);

    // Burst cap: 12-beat packet from 0 is cut at 8, requester 3 goes next.
    zero_seq();
    rq_len[0] = 12;
    for (int b = 0; b < 8; b++) exp_q.push_back(mk(0, b));
    for (int b = 0; b < 2; b++) exp_q.push_back(mk(3, b));
    for (int b = 8; b < 12; b++) exp_q.push_back(mk(0, b));
    for (int c = 0; c < 17; c++) begin
      step();
      if (c == 0) rq_len[3] = 2;
      if (c == 8) check("cap_cnt_last", 32'(s_cnt), 32'd7);
      if (c == 9) check("cap_bubble", 32'(s_busy), 32'd0);
      if (c == 10) check("cap_gid_3", 32'(s_gid), 32'd3);
      if (c == 12) check("cap_bubble2", 32'(s_busy), 32'd0);
      if (c == 13) check("cap_gid_0", 32'(s_gid), 32'd0);
    end
    wait_drain(20);

    // Backpressure: wr_full for 5 cycles mid-packet freezes everything.
    zero_seq();
    rq_len[2] = 4;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(2, b));
    for (int c = 0; c < 3; c++) step();
    wr_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_ready_%0d", c), 32'(s_rdy), 32'd0);
      check($sformatf("bp_wrv_%0d", c), 32'(s_wrv), 32'd1);
      check($sformatf("bp_cnt_%0d", c), 32'(s_cnt), 32'd2);
    end
    wr_full = 1'b0;
    wait_drain(20);

    // Valid gap: requester 1 pauses, grant held, requester 0 waits.
    zero_seq();
    rq_len[1] = 4;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(1, b));
    exp_q.push_back(mk(0, 0));
    for (int c = 0; c < 3; c++) step();
    rq_hold[1] = 1'b1;
    rq_len[0]  = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("gap_busy_%0d", c), 32'(s_busy), 32'd1);
      check($sformatf("gap_gid_%0d", c), 32'(s_gid), 32'd1);
      check($sformatf("gap_wrv_%0d", c), 32'(s_wrv), 32'd0);
    end
    rq_hold[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 2) check("gap_bubble", 32'(s_busy), 32'd0);
      if (c == 3) check("gap_gid_0", 32'(s_gid), 32'd0);
    end
    wait_drain(20);

    // Reset mid-packet: requester 3 cut during beat 2, requester 0 wins after.
    zero_seq();
    rq_len[3] = 5;
    exp_q.push_back(mk(3, 0));
    for (int c = 0; c < 2; c++) step();
    reset_n   = 1'b0;
    rq_len[0] = 1;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_wrv", 32'(wr_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    check("mrst_gid", 32'(grant_id), 32'd3);
    check("mrst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(mk(0, 0));
    for (int b = 1; b < 5; b++) exp_q.push_back(mk(3, b));
    for (int c = 0; c < 2; c++) begin
      step();
      if (c == 1) check("mrst_first_gid", 32'(s_gid), 32'd0);
    end
    wait_drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
